gate_vector_seq: RTL and testbench

Synchronous stimulus sequencer for the 5-input gate modules. It sits directly upstream of a gate under test: it drives an exhaustive 5-bit input vector (bit 0 = a, bit 4 = e), holds each vector for a programmable number of cycles, and samples the gate's single-bit response back into a 32-bit truth-table register. On hardware, this replaces the free-running stimulus counter so that gate behaviour can be captured and checked on-chip.

---
 rtl/gate_vector_seq_if.sv | 23 ++
 rtl/gate_vector_seq.sv | 143 ++++++++++++++
 tb/tb_gate_vector_seq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/gate_vector_seq_if.sv
// Stimulus/response bundle between gate_vector_seq and its controller.
// The master drives start/abort and the gate response; the sequencer (slave) drives the rest.
interface gate_vector_seq_if;
  logic        i_start;
  logic        i_abort;
  logic        i_y;
  logic [4:0]  o_vec;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_truth;
  logic        o_pass;
  logic [5:0]  o_err_cnt;

  modport master (
    output i_start, i_abort, i_y,
    input  o_vec, o_busy, o_done, o_truth, o_pass, o_err_cnt
  );

  modport slave (
    input  i_start, i_abort, i_y,
    output o_vec, o_busy, o_done, o_truth, o_pass, o_err_cnt
  );
endinterface

// File: rtl/gate_vector_seq.sv
// Exhaustive 5-bit stimulus sequencer that captures a gate's truth table.
// Optional golden compare against EXPECTED is built when GATE_VECTOR_SEQ_CHECK_EN is defined.
module gate_vector_seq #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter logic [31:0] EXPECTED    = 32'h0000_0000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  gate_vector_seq_if.slave  bus
);

  localparam int unsigned VEC_W  = 5;
  localparam int unsigned HCNT_W = 8;
  localparam int unsigned TT_W   = 32;
  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYCLES - 1);
  localparam logic [VEC_W-1:0]  VEC_LAST  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [TT_W-1:0]   truth_q, truth_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

`ifdef GATE_VECTOR_SEQ_CHECK_EN
  localparam int unsigned ERR_W = 6;
  localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(32);
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             pass_q, pass_d;
  logic             mismatch;
`endif

  // Next-state: abort dominates start and the final sample in every state.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hcnt_d  = hcnt_q;
    truth_d = truth_q;
`ifdef GATE_VECTOR_SEQ_CHECK_EN
    err_cnt_d = err_cnt_q;
    pass_d    = pass_q;
    mismatch  = (bus.i_y != EXPECTED[vec_q]);
`endif
    case (state_q)
      S_RUN: begin
        if (bus.i_abort) begin
          state_d = S_IDLE;
          vec_d   = '0;
          hcnt_d  = '0;
        end else if (hcnt_q == HOLD_LAST) begin
          hcnt_d         = '0;
          truth_d[vec_q] = bus.i_y;
`ifdef GATE_VECTOR_SEQ_CHECK_EN
          if (mismatch && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
          end
`endif
          if (vec_q == VEC_LAST) begin
            state_d = S_DONE;
            vec_d   = '0;
`ifdef GATE_VECTOR_SEQ_CHECK_EN
            pass_d  = (err_cnt_d == '0);
`endif
          end else begin
            vec_d = vec_q + VEC_W'(1);
          end
        end else begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end
      default: begin
        if (bus.i_abort) begin
          state_d = S_IDLE;
          vec_d   = '0;
          hcnt_d  = '0;
`ifdef GATE_VECTOR_SEQ_CHECK_EN
          pass_d  = 1'b0;
`endif
        end else if (bus.i_start) begin
          state_d = S_RUN;
          vec_d   = '0;
          hcnt_d  = '0;
          truth_d = '0;
`ifdef GATE_VECTOR_SEQ_CHECK_EN
          err_cnt_d = '0;
          pass_d    = 1'b0;
`endif
        end
      end
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      hcnt_q  <= '0;
      truth_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef GATE_VECTOR_SEQ_CHECK_EN
      err_cnt_q <= '0;
      pass_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hcnt_q  <= hcnt_d;
      truth_q <= truth_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef GATE_VECTOR_SEQ_CHECK_EN
      err_cnt_q <= err_cnt_d;
      pass_q    <= pass_d;
`endif
    end
  end

  assign bus.o_vec   = vec_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;
  assign bus.o_truth = truth_q;

`ifdef GATE_VECTOR_SEQ_CHECK_EN
  assign bus.o_pass    = pass_q;
  assign bus.o_err_cnt = err_cnt_q;
`else
  // Compare logic absent: results tied low, golden table has no load.
  logic unused_expected;
  assign unused_expected = ^EXPECTED;
  assign bus.o_pass      = 1'b0;
  assign bus.o_err_cnt   = '0;
`endif

endmodule

// File: tb/tb_gate_vector_seq.sv
// Directed bench for gate_vector_seq: instance A uses H=2, instance B uses H=1.
// Each instance drives a modelled 5-input AND or OR gate selected by the bench.
module tb_gate_vector_seq;

`ifdef GATE_VECTOR_SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk;
  logic rst;
  logic gate_or_a;
  logic gate_or_b;
  int   n_pass;
  int   n_total;

  gate_vector_seq_if if_a ();
  gate_vector_seq_if if_b ();

  gate_vector_seq #(.HOLD_CYCLES(2), .EXPECTED(32'h8000_0000)) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(if_a.slave)
  );
  gate_vector_seq #(.HOLD_CYCLES(1), .EXPECTED(32'hFFFF_FFFE)) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(if_b.slave)
  );

  assign if_a.i_y = gate_or_a ? (|if_a.o_vec) : (&if_a.o_vec);
  assign if_b.i_y = gate_or_b ? (|if_b.o_vec) : (&if_b.o_vec);

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_a.i_start = 1'b1;
    step();
    step();
    if_a.i_start = 1'b0;
    n_total++; if (if_a.o_busy !== 1'b0) $display("FAIL rst_busy_a got %0b want 0", if_a.o_busy); else n_pass++;
    n_total++; if (if_a.o_done !== 1'b0) $display("FAIL rst_done_a got %0b want 0", if_a.o_done); else n_pass++;
    n_total++; if (if_a.o_vec !== 5'd0) $display("FAIL rst_vec_a got %0d want 0", if_a.o_vec); else n_pass++;
    n_total++; if (if_a.o_truth !== 32'h0) $display("FAIL rst_truth_a got %h want 0", if_a.o_truth); else n_pass++;
    n_total++; if (if_a.o_pass !== 1'b0) $display("FAIL rst_pass_a got %0b want 0", if_a.o_pass); else n_pass++;
    n_total++; if (if_a.o_err_cnt !== 6'd0) $display("FAIL rst_err_a got %0d want 0", if_a.o_err_cnt); else n_pass++;
    n_total++; if (if_b.o_busy !== 1'b0) $display("FAIL rst_busy_b got %0b want 0", if_b.o_busy); else n_pass++;
    rst = 1'b0;
    step();
    n_total++; if (if_a.o_busy !== 1'b0) $display("FAIL idle_hold_busy_a got %0b want 0", if_a.o_busy); else n_pass++;
  endtask

  task automatic test_and_h2();
    gate_or_a = 1'b0;
    if_a.i_start = 1'b1;
    step();
    if_a.i_start = 1'b0;
    n_total++; if (if_a.o_busy !== 1'b1) $display("FAIL and_start_busy got %0b want 1", if_a.o_busy); else n_pass++;
    n_total++; if (if_a.o_vec !== 5'd0) $display("FAIL and_start_vec got %0d want 0", if_a.o_vec); else n_pass++;
    repeat (63) step();
    n_total++; if (if_a.o_done !== 1'b0) $display("FAIL and_early_done got %0b want 0", if_a.o_done); else n_pass++;
    n_total++; if (if_a.o_vec !== 5'd31) $display("FAIL and_last_vec got %0d want 31", if_a.o_vec); else n_pass++;
    step();
    n_total++; if (if_a.o_done !== 1'b1) $display("FAIL and_done got %0b want 1", if_a.o_done); else n_pass++;
    n_total++; if (if_a.o_busy !== 1'b0) $display("FAIL and_busy got %0b want 0", if_a.o_busy); else n_pass++;
    n_total++; if (if_a.o_vec !== 5'd0) $display("FAIL and_vec got %0d want 0", if_a.o_vec); else n_pass++;
    n_total++; if (if_a.o_truth !== 32'h8000_0000) $display("FAIL and_truth got %h want 80000000", if_a.o_truth); else n_pass++;
    n_total++; if (if_a.o_pass !== CHK) $display("FAIL and_pass got %0b want %0b", if_a.o_pass, CHK); else n_pass++;
    n_total++; if (if_a.o_err_cnt !== 6'd0) $display("FAIL and_err got %0d want 0", if_a.o_err_cnt); else n_pass++;
  endtask

  task automatic test_or_h1();
    gate_or_b = 1'b1;
    if_b.i_start = 1'b1;
    step();
    if_b.i_start = 1'b0;
    n_total++; if (if_b.o_busy !== 1'b1) $display("FAIL or_start_busy got %0b want 1", if_b.o_busy); else n_pass++;
    n_total++; if (if_b.o_vec !== 5'd0) $display("FAIL or_start_vec got %0d want 0", if_b.o_vec); else n_pass++;
    for (int j = 1; j < 32; j++) begin
      step();
      n_total++; if (if_b.o_vec !== 5'(j)) $display("FAIL or_vec_step got %0d want %0d", if_b.o_vec, j); else n_pass++;
    end
    step();
    n_total++; if (if_b.o_done !== 1'b1) $display("FAIL or_done got %0b want 1", if_b.o_done); else n_pass++;
    n_total++; if (if_b.o_vec !== 5'd0) $display("FAIL or_vec_end got %0d want 0", if_b.o_vec); else n_pass++;
    n_total++; if (if_b.o_truth !== 32'hFFFF_FFFE) $display("FAIL or_truth got %h want fffffffe", if_b.o_truth); else n_pass++;
    n_total++; if (if_b.o_pass !== CHK) $display("FAIL or_pass got %0b want %0b", if_b.o_pass, CHK); else n_pass++;
    n_total++; if (if_b.o_err_cnt !== 6'd0) $display("FAIL or_err got %0d want 0", if_b.o_err_cnt); else n_pass++;
  endtask

  // AND response against an OR-shaped golden: bits 1..30 disagree, bits 0 and 31 agree.
  task automatic test_check_mismatch();
    gate_or_b = 1'b0;
    if_b.i_start = 1'b1;
    step();
    if_b.i_start = 1'b0;
    n_total++; if (if_b.o_truth !== 32'h0) $display("FAIL mm_clear_truth got %h want 0", if_b.o_truth); else n_pass++;
    n_total++; if (if_b.o_done !== 1'b0) $display("FAIL mm_clear_done got %0b want 0", if_b.o_done); else n_pass++;
    repeat (32) step();
    n_total++; if (if_b.o_done !== 1'b1) $display("FAIL mm_done got %0b want 1", if_b.o_done); else n_pass++;
    n_total++; if (if_b.o_truth !== 32'h8000_0000) $display("FAIL mm_truth got %h want 80000000", if_b.o_truth); else n_pass++;
    n_total++; if (if_b.o_err_cnt !== (CHK ? 6'd30 : 6'd0)) $display("FAIL mm_err got %0d want %0d", if_b.o_err_cnt, CHK ? 30 : 0); else n_pass++;
    n_total++; if (if_b.o_pass !== 1'b0) $display("FAIL mm_pass got %0b want 0", if_b.o_pass); else n_pass++;
  endtask

  task automatic test_abort();
    gate_or_a = 1'b1;
    if_a.i_start = 1'b1;
    step();
    if_a.i_start = 1'b0;
    repeat (21) step();
    if_a.i_abort = 1'b1;
    step();
    if_a.i_abort = 1'b0;
    n_total++; if (if_a.o_busy !== 1'b0) $display("FAIL abort_busy got %0b want 0", if_a.o_busy); else n_pass++;
    n_total++; if (if_a.o_done !== 1'b0) $display("FAIL abort_done got %0b want 0", if_a.o_done); else n_pass++;
    n_total++; if (if_a.o_vec !== 5'd0) $display("FAIL abort_vec got %0d want 0", if_a.o_vec); else n_pass++;
    n_total++; if (if_a.o_truth !== 32'h0000_03FE) $display("FAIL abort_truth got %h want 000003fe", if_a.o_truth); else n_pass++;
    repeat (3) step();
    n_total++; if (if_a.o_truth !== 32'h0000_03FE) $display("FAIL abort_hold_truth got %h want 000003fe", if_a.o_truth); else n_pass++;
    if_a.i_start = 1'b1;
    step();
    if_a.i_start = 1'b0;
    n_total++; if (if_a.o_truth !== 32'h0) $display("FAIL rerun_clear got %h want 0", if_a.o_truth); else n_pass++;
    repeat (64) step();
    n_total++; if (if_a.o_done !== 1'b1) $display("FAIL rerun_done got %0b want 1", if_a.o_done); else n_pass++;
    n_total++; if (if_a.o_truth !== 32'hFFFF_FFFE) $display("FAIL rerun_truth got %h want fffffffe", if_a.o_truth); else n_pass++;
    n_total++; if (if_a.o_err_cnt !== (CHK ? 6'd30 : 6'd0)) $display("FAIL rerun_err got %0d want %0d", if_a.o_err_cnt, CHK ? 30 : 0); else n_pass++;
  endtask

  task automatic test_done_restart();
    if_a.i_start = 1'b1;
    step();
    if_a.i_start = 1'b0;
    n_total++; if (if_a.o_busy !== 1'b1) $display("FAIL restart_busy got %0b want 1", if_a.o_busy); else n_pass++;
    n_total++; if (if_a.o_done !== 1'b0) $display("FAIL restart_done got %0b want 0", if_a.o_done); else n_pass++;
    n_total++; if (if_a.o_truth !== 32'h0) $display("FAIL restart_truth got %h want 0", if_a.o_truth); else n_pass++;
    repeat (64) step();
    n_total++; if (if_a.o_done !== 1'b1) $display("FAIL restart_end_done got %0b want 1", if_a.o_done); else n_pass++;
    if_a.i_start = 1'b1;
    if_a.i_abort = 1'b1;
    step();
    if_a.i_start = 1'b0;
    if_a.i_abort = 1'b0;
    n_total++; if (if_a.o_busy !== 1'b0) $display("FAIL both_busy got %0b want 0", if_a.o_busy); else n_pass++;
    n_total++; if (if_a.o_done !== 1'b0) $display("FAIL both_done got %0b want 0", if_a.o_done); else n_pass++;
    n_total++; if (if_a.o_truth !== 32'hFFFF_FFFE) $display("FAIL both_truth got %h want fffffffe", if_a.o_truth); else n_pass++;
    n_total++; if (if_a.o_pass !== 1'b0) $display("FAIL both_pass got %0b want 0", if_a.o_pass); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    if_a.i_start = 1'b1;
    step();
    if_a.i_start = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      if (j == 5) if_a.i_start = 1'b1;
      step();
      if_a.i_start = 1'b0;
      n_total++; if (if_a.o_vec !== 5'(j / 2)) $display("FAIL midrun_vec got %0d want %0d", if_a.o_vec, j / 2); else n_pass++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_total++; if (if_a.o_busy !== 1'b0) $display("FAIL midrst_busy got %0b want 0", if_a.o_busy); else n_pass++;
    n_total++; if (if_a.o_vec !== 5'd0) $display("FAIL midrst_vec got %0d want 0", if_a.o_vec); else n_pass++;
    n_total++; if (if_a.o_truth !== 32'h0) $display("FAIL midrst_truth got %h want 0", if_a.o_truth); else n_pass++;
    n_total++; if (if_b.o_done !== 1'b0) $display("FAIL midrst_done_b got %0b want 0", if_b.o_done); else n_pass++;
    step();
    n_total++; if (if_a.o_busy !== 1'b0) $display("FAIL midrst_idle got %0b want 0", if_a.o_busy); else n_pass++;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    gate_or_a = 1'b0;
    gate_or_b = 1'b0;
    if_a.i_start = 1'b0;
    if_a.i_abort = 1'b0;
    if_b.i_start = 1'b0;
    if_b.i_abort = 1'b0;
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_and_h2();
    test_or_h1();
    test_check_mismatch();
    test_abort();
    test_done_restart();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
